// File: rtl/wca_rx_pkg.sv
// Shared types and arithmetic helpers for the receive-path sample packer.
// Covers DC-bias correction with saturation and the 12-bit packed word layouts.
package wca_rx_pkg;

  localparam int SAMPLE_W = 12;
  localparam int WORD_W   = 16;

  localparam logic MODE_UNPACKED = 1'b0;
  localparam logic MODE_PACKED12 = 1'b1;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 12'sh7FF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 12'sh800;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

  // What the sample held in the write stage turns into.
  typedef enum logic [1:0] {
    KIND_UNP = 2'd0,
    KIND_PA  = 2'd1,
    KIND_PB  = 2'd2
  } kind_t;

  function automatic logic signed [SAMPLE_W-1:0] sat12_sub(
    input logic signed [SAMPLE_W-1:0] x,
    input logic signed [SAMPLE_W-1:0] b
  );
    logic signed [SAMPLE_W:0] d;
    d = {x[SAMPLE_W-1], x} - {b[SAMPLE_W-1], b};
    if (d[SAMPLE_W] != d[SAMPLE_W-1]) begin
      return d[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    end
    return d[SAMPLE_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] sext16(input logic signed [SAMPLE_W-1:0] c);
    return {{(WORD_W-SAMPLE_W){c[SAMPLE_W-1]}}, c};
  endfunction

  function automatic logic [WORD_W-1:0] pack_w0(
    input logic signed [SAMPLE_W-1:0] i0,
    input logic signed [SAMPLE_W-1:0] q0
  );
    return {q0[3:0], i0};
  endfunction

  function automatic logic [WORD_W-1:0] pack_w1(
    input logic signed [SAMPLE_W-1:0] i1,
    input logic        [7:0]          q0_hi
  );
    return {i1[7:0], q0_hi};
  endfunction

  function automatic logic [WORD_W-1:0] pack_w2(
    input logic signed [SAMPLE_W-1:0] i1,
    input logic signed [SAMPLE_W-1:0] q1
  );
    return {q1, i1[11:8]};
  endfunction

endpackage

// File: rtl/wca_rx_packer_if.sv
// Word stream from the packer FIFO toward the DMA/USB streaming logic.
// The master side presents show-ahead data; the slave side accepts with out_ready.
interface wca_rx_packer_if;
  import wca_rx_pkg::*;

  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/wca_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy output.
// The head word is driven combinationally; it reads as zero while empty.
module wca_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;

  assign valid   = (level != '0);
  assign do_rd   = rd_en & valid;
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(wr_en) - LW'(do_rd);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/wca_rx_packer.sv
// Receive-path packer: bias-corrects I/Q samples, packs them into 16-bit words
// (unpacked or 12-bit packed) and queues them in a FIFO, counting dropped samples.
module wca_rx_packer
  import wca_rx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNTW  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        mode,
  input  logic                        clr_stats,
  input  logic                        strobe,
  input  logic signed [SAMPLE_W-1:0]  rx_i,
  input  logic signed [SAMPLE_W-1:0]  rx_q,
  input  logic signed [SAMPLE_W-1:0]  bias_i,
  input  logic signed [SAMPLE_W-1:0]  bias_q,
  wca_rx_packer_if.master             out_if,
  output logic [$clog2(DEPTH):0]      level,
  output logic [CNTW-1:0]             overflow_count,
  output logic                        overflow_flag
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic                       mode_q;
  phase_t                     phase;
  logic [7:0]                 resid;

  logic signed [SAMPLE_W-1:0] ci_p0;
  logic signed [SAMPLE_W-1:0] cq_p0;
  logic [LW-1:0]              need_p0;
  logic [LW-1:0]              free_p0;
  logic                       accept_p0;
  logic                       drop_p0;

  logic                       vld_p1;
  kind_t                      kind_p1;
  logic signed [SAMPLE_W-1:0] ci_p1;
  logic signed [SAMPLE_W-1:0] cq_p1;
  logic [7:0]                 resid_p1;

  logic                       vld_p2;
  logic [WORD_W-1:0]          w2_p2;

  logic                       wr_en;
  logic [WORD_W-1:0]          wr_data;

  // Stage p0: correction and admission at the strobe cycle.
  assign ci_p0 = sat12_sub(rx_i, bias_i);
  assign cq_p0 = sat12_sub(rx_q, bias_q);

  // Free space discounts a second word still in flight this cycle, so a
  // reservation made here always holds when the writes land.
  always_comb begin
    need_p0 = LW'(2);
    if (mode_q == MODE_PACKED12) begin
      need_p0 = (phase == PH_A) ? LW'(3) : LW'(0);
    end
    free_p0   = LW'(DEPTH) - level - LW'(vld_p2);
    accept_p0 = enable & strobe & ~vld_p1 & (free_p0 >= need_p0);
    drop_p0   = enable & strobe & ~accept_p0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q         <= MODE_UNPACKED;
      phase          <= PH_A;
      vld_p1         <= 1'b0;
      kind_p1        <= KIND_UNP;
      vld_p2         <= 1'b0;
      overflow_count <= '0;
      overflow_flag  <= 1'b0;
    end else begin
      if (!enable) mode_q <= mode;

      if (!enable) begin
        phase <= PH_A;
      end else if (accept_p0 && mode_q == MODE_PACKED12) begin
        phase <= (phase == PH_A) ? PH_B : PH_A;
      end

      vld_p1 <= accept_p0;
      if (accept_p0) begin
        kind_p1 <= (mode_q == MODE_UNPACKED) ? KIND_UNP :
                   ((phase == PH_A) ? KIND_PA : KIND_PB);
      end
      vld_p2 <= vld_p1 && (kind_p1 != KIND_PA);

      if (clr_stats) begin
        overflow_count <= '0;
        overflow_flag  <= 1'b0;
      end else if (drop_p0) begin
        if (overflow_count != {CNTW{1'b1}}) overflow_count <= overflow_count + CNTW'(1);
        overflow_flag <= 1'b1;
      end
    end
  end

  // Stage p1: corrected sample registered; residue snapshot travels with it so
  // an enable drop after admission cannot corrupt the W1 that follows.
  always_ff @(posedge clock) begin
    if (accept_p0) begin
      ci_p1    <= ci_p0;
      cq_p1    <= cq_p0;
      resid_p1 <= resid;
    end
    if (accept_p0 && mode_q == MODE_PACKED12 && phase == PH_A) begin
      resid <= cq_p0[11:4];
    end
  end

  // Stage p2: second word of the pair waits one cycle for its write slot.
  always_ff @(posedge clock) begin
    if (vld_p1) begin
      w2_p2 <= (kind_p1 == KIND_PB) ? pack_w2(ci_p1, cq_p1) : sext16(cq_p1);
    end
  end

  always_comb begin
    wr_en   = vld_p1 | vld_p2;
    wr_data = w2_p2;
    if (vld_p1) begin
      case (kind_p1)
        KIND_PA: wr_data = pack_w0(ci_p1, cq_p1);
        KIND_PB: wr_data = pack_w1(ci_p1, resid_p1);
        default: wr_data = sext16(ci_p1);
      endcase
    end
  end

  wca_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (out_if.out_ready),
    .rd_data (out_if.out_data),
    .valid   (out_if.out_valid),
    .level   (level)
  );

endmodule

// File: tb/tb_wca_rx_packer.sv
// Bench for wca_rx_packer: vector table, hand-written corner sequences and a
// randomized run, all checked against a word-queue reference model.
module tb_wca_rx_packer;

  localparam int DEPTH_T = 8;
  localparam int CNTW_T  = 4;
  localparam int CNT_MAX = (1 << CNTW_T) - 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode;
  logic        clr_stats;
  logic        strobe;
  logic [11:0] rx_i, rx_q, bias_i, bias_q;
  logic [3:0]  level;
  logic [3:0]  overflow_count;
  logic        overflow_flag;

  wca_rx_packer_if bus ();

  wca_rx_packer #(
    .DEPTH (DEPTH_T),
    .CNTW  (CNTW_T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .mode           (mode),
    .clr_stats      (clr_stats),
    .strobe         (strobe),
    .rx_i           (rx_i),
    .rx_q           (rx_q),
    .bias_i         (bias_i),
    .bias_q         (bias_q),
    .out_if         (bus),
    .level          (level),
    .overflow_count (overflow_count),
    .overflow_flag  (overflow_flag)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: words owed to the consumer, plus when each lands.
  logic [15:0] exp_q [$];
  int          land_q [$];
  int          committed, written, pops, last_admit;
  int          m_cnt, m_resid;
  bit          m_flag, m_mode, m_ph;

  typedef struct {
    logic [11:0] i, q, bi, bq;
    logic [15:0] wa, wb;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int corr(input logic [11:0] x, input logic [11:0] b);
    int d;
    d = int'($signed(x)) - int'($signed(b));
    if (d > 2047)  d = 2047;
    if (d < -2048) d = -2048;
    return d;
  endfunction

  task automatic step();
    int  need, freew, ci, cq, ui, uq, occ;
    bit  was_reset;
    was_reset = !reset;
    if (was_reset) begin
      exp_q.delete();
      land_q.delete();
      committed = 0; written = 0; pops = 0; last_admit = -10;
      m_cnt = 0; m_flag = 0; m_mode = 0; m_ph = 0; m_resid = 0;
    end else begin
      if (enable && strobe) begin
        ci = corr(rx_i, bias_i);
        cq = corr(rx_q, bias_q);
        ui = ci & 32'hFFF;
        uq = cq & 32'hFFF;
        need  = !m_mode ? 2 : (m_ph ? 0 : 3);
        freew = DEPTH_T - (committed - pops);
        if ((cyc - last_admit) == 1 || freew < need) begin
          if (m_cnt < CNT_MAX) m_cnt++;
          m_flag = 1'b1;
        end else begin
          last_admit = cyc;
          if (!m_mode) begin
            exp_q.push_back(16'(ci));
            exp_q.push_back(16'(cq));
            land_q.push_back(cyc + 1);
            land_q.push_back(cyc + 2);
            committed += 2;
          end else if (!m_ph) begin
            exp_q.push_back(16'((uq % 16) * 4096 + ui));
            m_resid = uq / 16;
            land_q.push_back(cyc + 1);
            committed += 1;
            m_ph = 1'b1;
          end else begin
            exp_q.push_back(16'((ui % 256) * 256 + m_resid));
            exp_q.push_back(16'(uq * 16 + ui / 256));
            land_q.push_back(cyc + 1);
            land_q.push_back(cyc + 2);
            committed += 2;
            m_ph = 1'b0;
          end
        end
      end
      if (clr_stats) begin
        m_cnt = 0;
        m_flag = 1'b0;
      end
      if (!enable) begin
        m_ph = 1'b0;
        m_mode = mode;
      end
      if ((written - pops) > 0 && bus.out_ready) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
    @(posedge clock);
    #1;
    while (land_q.size() > 0 && land_q[0] <= cyc) begin
      void'(land_q.pop_front());
      written++;
    end
    cyc++;
    occ = written - pops;
    chk("level", 32'(level), occ);
    chk("out_valid", 32'(bus.out_valid), (occ != 0) ? 1 : 0);
    if (occ > 0) chk("head_word", 32'(bus.out_data), 32'(exp_q[0]));
    chk("overflow_count", 32'(overflow_count), m_cnt);
    chk("overflow_flag", 32'(overflow_flag), 32'(m_flag));
    if (was_reset) chk("reset_out_data", 32'(bus.out_data), 0);
  endtask

  task automatic pulse_strobe(input logic [11:0] i, input logic [11:0] q);
    rx_i = i;
    rx_q = q;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
  endtask

  task automatic set_mode(input logic m);
    enable = 1'b0;
    mode = m;
    step();
    enable = 1'b1;
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (written == pops && land_q.size() == 0) break;
      step();
    end
    bus.out_ready = 1'b0;
    chk("drain_level", 32'(level), 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 1'b0; clr_stats = 1'b0; strobe = 1'b0;
    rx_i = '0; rx_q = '0; bias_i = '0; bias_q = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{12'h123, 12'hF00, 12'h000, 12'h000, 16'h0123, 16'hFF00};
    tbl[1] = '{12'h800, 12'd100, 12'h001, 12'd100, 16'hF800, 16'h0000};
    tbl[2] = '{12'h7FF, 12'h800, 12'hFFF, 12'hFFF, 16'h07FF, 16'hF801};
    tbl[3] = '{12'h000, 12'hFFF, 12'h7FF, 12'h7FF, 16'hF801, 16'hF800};
    tbl[4] = '{12'h7FF, 12'h800, 12'h800, 12'h7FF, 16'h07FF, 16'hF800};

    step();
    step();
    chk("reset_level", 32'(level), 0);
    chk("reset_valid", 32'(bus.out_valid), 0);
    reset = 1'b1;
    set_mode(1'b0);

    // Mode 0 correction vectors, one sample at a time from an empty FIFO.
    for (int v = 0; v < 5; v++) begin
      bias_i = tbl[v].bi;
      bias_q = tbl[v].bq;
      pulse_strobe(tbl[v].i, tbl[v].q);
      chk("latency_n1_valid", 32'(bus.out_valid), 0);
      step();
      chk("latency_n2_valid", 32'(bus.out_valid), 1);
      chk("tbl_word_a", 32'(bus.out_data), 32'(tbl[v].wa));
      bus.out_ready = 1'b1;
      step();
      chk("tbl_word_b", 32'(bus.out_data), 32'(tbl[v].wb));
      step();
      bus.out_ready = 1'b0;
      chk("tbl_empty", 32'(level), 0);
    end
    bias_i = '0;
    bias_q = '0;

    // Sustained stream at the minimum spacing, then a back-to-back strobe.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pulse_strobe(12'h123, 12'hF00);
      step();
    end
    bus.out_ready = 1'b0;
    drain();
    pulse_strobe(12'h050, 12'h060);
    pulse_strobe(12'h070, 12'h080);
    step();
    chk("busy_drop_count", 32'(overflow_count), 1);
    chk("busy_drop_flag", 32'(overflow_flag), 1);
    chk("busy_drop_level", 32'(level), 2);
    drain();
    clear_stats();

    // Packed mode: one full pair, then a fresh PH_A sample.
    set_mode(1'b1);
    pulse_strobe(12'hABC, 12'h123);
    step();
    chk("pk_level1", 32'(level), 1);
    chk("pk_w0", 32'(bus.out_data), 32'h3ABC);
    pulse_strobe(12'h456, 12'h789);
    step();
    step();
    chk("pk_level3", 32'(level), 3);
    bus.out_ready = 1'b1;
    chk("pk_head_w0", 32'(bus.out_data), 32'h3ABC);
    step();
    chk("pk_w1", 32'(bus.out_data), 32'h5612);
    step();
    chk("pk_w2", 32'(bus.out_data), 32'h7894);
    step();
    bus.out_ready = 1'b0;
    chk("pk_empty", 32'(level), 0);
    pulse_strobe(12'h111, 12'h222);
    step();
    chk("pk_phase_back_a", 32'(bus.out_data), 32'h2111);
    // Enable dropped while in PH_B: the next sample must use the W0 layout.
    enable = 1'b0;
    step();
    enable = 1'b1;
    pulse_strobe(12'h345, 12'h678);
    step();
    chk("en_drop_level", 32'(level), 2);
    bus.out_ready = 1'b1;
    step();
    chk("en_drop_w0", 32'(bus.out_data), 32'h8345);
    step();
    bus.out_ready = 1'b0;
    chk("en_drop_empty", 32'(level), 0);

    // Overflow into a stalled FIFO, counter saturation, clear priority.
    set_mode(1'b0);
    for (int k = 0; k < 5; k++) begin
      pulse_strobe(12'(k + 1), 12'(k + 16));
      step();
    end
    chk("ovf_level", 32'(level), 8);
    chk("ovf_count", 32'(overflow_count), 1);
    chk("ovf_flag", 32'(overflow_flag), 1);
    clear_stats();
    chk("clr_count", 32'(overflow_count), 0);
    chk("clr_flag", 32'(overflow_flag), 0);
    chk("clr_level", 32'(level), 8);
    for (int k = 0; k < 16; k++) begin
      pulse_strobe(12'h001, 12'h002);
      step();
    end
    chk("sat_count", 32'(overflow_count), CNT_MAX);
    clr_stats = 1'b1;
    pulse_strobe(12'h003, 12'h004);
    clr_stats = 1'b0;
    chk("clr_wins_count", 32'(overflow_count), 0);
    chk("clr_wins_flag", 32'(overflow_flag), 0);
    drain();

    // PH_A reservation: two free words is not enough, three is.
    for (int k = 0; k < 3; k++) begin
      pulse_strobe(12'(k + 32), 12'(k + 48));
      step();
    end
    set_mode(1'b1);
    chk("rsv_level6", 32'(level), 6);
    pulse_strobe(12'h0AB, 12'h00C);
    step();
    chk("rsv_drop_count", 32'(overflow_count), 1);
    chk("rsv_drop_level", 32'(level), 6);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("rsv_level5", 32'(level), 5);
    pulse_strobe(12'h0AB, 12'h00C);
    step();
    chk("rsv_admit_level", 32'(level), 6);
    chk("rsv_admit_count", 32'(overflow_count), 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("rsv_w0", 32'(bus.out_data), 32'hC0AB);
    step();
    bus.out_ready = 1'b0;
    chk("rsv_empty", 32'(level), 0);

    // Reset asserted mid-stream.
    set_mode(1'b0);
    pulse_strobe(12'h5A5, 12'h0F0);
    reset = 1'b0;
    step();
    chk("midrst_level", 32'(level), 0);
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_count", 32'(overflow_count), 0);
    chk("midrst_flag", 32'(overflow_flag), 0);
    reset = 1'b1;
    enable = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if (enable) begin
        if ($urandom_range(0, 99) < 2) enable = 1'b0;
      end else begin
        mode = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) < 30) enable = 1'b1;
      end
      strobe = ($urandom_range(0, 99) < 45);
      rx_i = 12'($urandom);
      rx_q = 12'($urandom);
      if ((k % 64) == 0) begin
        bias_i = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
        bias_q = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      end
      bus.out_ready = ($urandom_range(0, 99) < 55);
      clr_stats = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 999) >= 3);
      step();
    end
    reset = 1'b1;
    strobe = 1'b0;
    clr_stats = 1'b0;
    enable = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
